mvu_job_ctrl: RTL and testbench
===============================

// Module: mvu_job_ctrl
// PURPOSE
//  Job sequencer for one MVU lane of mvutop. Accepts job descriptors from the host over valid/ready
//  and queues them in a QDEPTH-entry FIFO. For each job it drives the precision, countdown and
//  quantizer config lines. It sequences clear -> run -> quantize, then pulses done.
//  One instance per MVU; NMVU instances sit between the host CSR block and mvutop.
// PARAMETERS
//  QDEPTH    2   job FIFO depth (power of 2, >=2)
//  QLAT      4   cycles spent in QUANT state (quantizer drain), >=1
//  BCNTDWN  29   countdown width (from mvu_pkg)
//  BPREC     6   precision field width (from mvu_pkg)
//  BQMSBIDX  5   quantizer MSB index width, $clog2(BACC=32) (from mvu_pkg)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        synchronous active-low reset
//  job_valid      in   1        descriptor valid
//  job_ready      out  1        FIFO not full (registered occupancy only)
//  job_countdown  in   BCNTDWN  run length in cycles
//  job_wprec      in   BPREC    weight precision
//  job_iprec      in   BPREC    input precision
//  job_oprec      in   BPREC    output precision
//  job_msbidx     in   BQMSBIDX quantizer MSB index
//  job_mul_mode   in   2        multiplier mode
//  abort          in   1        flush FIFO, kill current job
//  countdown      out  BCNTDWN  to mvutop.countdown
//  wprecision     out  BPREC    to mvutop.wprecision
//  iprecision     out  BPREC    to mvutop.iprecision
//  oprecision     out  BPREC    to mvutop.oprecision
//  quant_msbidx   out  BQMSBIDX to mvutop.quant_msbidx
//  mul_mode       out  2        to mvutop.mul_mode
//  start          out  1        1-cycle pulse, first RUN cycle
//  acc_clr        out  1        accumulator clear
//  max_clr        out  1        max-pool clear
//  quant_clr      out  1        quantizer clear
//  quant_start    out  1        1-cycle pulse, first QUANT cycle
//  busy           out  1        state != IDLE
//  done           out  1        1-cycle pulse, job completed normally
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, all outputs 0 except job_ready=1. rst_n has priority over abort.
//  Push when job_valid&&job_ready. job_ready derives from registered count, so no push into a
//   full FIFO even if a pop occurs in the same cycle. Push and pop in one cycle leave count unchanged.
//  FSM states: IDLE, SETUP, RUN, QUANT, DONE.
//  IDLE: if FIFO non-empty, pop and latch descriptor into config regs -> SETUP.
//  SETUP (1 cyc): acc_clr=max_clr=quant_clr=1; cnt<=countdown. countdown==0 -> DONE (no start,
//   no quant_start); else -> RUN.
//  RUN: start=1 on first cycle only; cnt decrements every cycle; cnt==1 -> QUANT. Lasts exactly C cycles.
//  QUANT: quant_start=1 on first cycle; stays QLAT cycles -> DONE.
//  DONE (1 cyc): done=1 -> IDLE.
//  Config outputs hold the latched job from SETUP through DONE and keep their value in IDLE.
//  Latency: push at cycle t into empty FIFO in IDLE -> SETUP t+2, start t+3, quant_start t+3+C,
//   done t+3+C+QLAT. Back-to-back jobs spend 1 IDLE cycle between DONE and the next SETUP.
//  abort (any state): next cycle state=IDLE, FIFO empty, acc_clr=1 for that cycle.
//   done is not pulsed. A push coincident with abort is dropped.
// STRUCTURE
//  mvu_pkg: BCNTDWN, BPREC, BQMSBIDX, BACC; typedef struct packed mvu_job_t (descriptor fields);
//   typedef enum logic[2:0] mvu_ctrl_state_e.
//  Sub-module mvu_job_fifo: sync FIFO of mvu_job_t, QDEPTH entries, count/full/empty.
// TESTING
//  1 rst_n low 3 cyc -> job_ready=1, busy=0, all strobes 0, config outputs 0.
//  2 one job C=5, QLAT=4, push t=10 -> SETUP 12 (clears high), start 13, quant_start 18, done 22.
//  3 three jobs C=3 pushed back-to-back, QDEPTH=2 -> job_ready low when 2 queued;
//    three done pulses, 1 idle cycle between each DONE and the next SETUP.
//  4 job countdown=0 -> SETUP then done next cycle; start and quant_start never assert.
//  5 abort in RUN cycle 2 with 1 job queued -> IDLE next cycle, acc_clr=1, FIFO empty, no done.
//  6 rst_n low mid-QUANT with valid held -> IDLE, FIFO empty, no done, no push on the reset cycle.

Source files
------------

// File: rtl/mvu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_pkg
//  Description : Shared widths, the job descriptor type and the job
//                controller state encoding for the MVU lane control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvu_pkg;

    localparam int BACC     = 32;
    localparam int BCNTDWN  = 29;
    localparam int BPREC    = 6;
    localparam int BQMSBIDX = $clog2(BACC);

    // One queued job as pushed by the host
    typedef struct packed {
        logic [BCNTDWN-1:0]  countdown;
        logic [BPREC-1:0]    wprec;
        logic [BPREC-1:0]    iprec;
        logic [BPREC-1:0]    oprec;
        logic [BQMSBIDX-1:0] msbidx;
        logic [1:0]          mul_mode;
    } mvu_job_t;

    // State codes kept as plain constants so older code can compare against them
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_quant = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_st_idle,
        ST_SETUP = c_st_setup,
        ST_RUN   = c_st_run,
        ST_QUANT = c_st_quant,
        ST_DONE  = c_st_done
    } mvu_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/mvu_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_job_fifo
//  Description : Synchronous FIFO of mvu_job_t descriptors with flush.
//                Ports: clk, rst_n (sync, active low), flush, push, pop,
//                din, dout (head entry, combinational), full, empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  mvu_job_t din,
    output mvu_job_t dout,
    output logic     full,
    output logic     empty
);

    localparam int c_aw = $clog2(DEPTH);

    mvu_job_t          r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Flush beats both push and pop so a same-cycle push is discarded
    assign w_push = rst_n && !flush && push && !full;
    assign w_pop  = rst_n && !flush && pop && !empty;

    assign full  = (r_count == (c_aw+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mvu_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_job_ctrl
//  Description : Job sequencer for one MVU lane. Queues host descriptors,
//                drives the lane config lines and sequences
//                clear -> run -> quantize -> done for each job.
//                Ports: host side job_* valid/ready + descriptor, abort;
//                lane side config (countdown, *precision, quant_msbidx,
//                mul_mode) and strobes (start, acc/max/quant_clr,
//                quant_start, done), plus busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_job_ctrl
    import mvu_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int QLAT   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [BCNTDWN-1:0]  job_countdown,
    input  logic [BPREC-1:0]    job_wprec,
    input  logic [BPREC-1:0]    job_iprec,
    input  logic [BPREC-1:0]    job_oprec,
    input  logic [BQMSBIDX-1:0] job_msbidx,
    input  logic [1:0]          job_mul_mode,
    input  logic                abort,
    output logic [BCNTDWN-1:0]  countdown,
    output logic [BPREC-1:0]    wprecision,
    output logic [BPREC-1:0]    iprecision,
    output logic [BPREC-1:0]    oprecision,
    output logic [BQMSBIDX-1:0] quant_msbidx,
    output logic [1:0]          mul_mode,
    output logic                start,
    output logic                acc_clr,
    output logic                max_clr,
    output logic                quant_clr,
    output logic                quant_start,
    output logic                busy,
    output logic                done
);

    mvu_job_t           w_job_in;
    mvu_job_t           w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    mvu_ctrl_state_e    r_state;
    logic [BCNTDWN-1:0] r_cnt;
    logic               r_abort_d;

    assign w_job_in = '{countdown: job_countdown, wprec: job_wprec, iprec: job_iprec,
                        oprec: job_oprec, msbidx: job_msbidx, mul_mode: job_mul_mode};

    // Ready comes from registered occupancy only, so a pop in the same
    // cycle never opens a slot early
    assign job_ready = !w_full;
    assign w_push    = job_valid && job_ready && !abort;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && !abort;

    mvu_job_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_job_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // r_cnt counts the RUN length down from countdown, then is reloaded
    // with QLAT and reused to time the quantizer drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_abort_d    <= 1'b0;
            countdown    <= '0;
            wprecision   <= '0;
            iprecision   <= '0;
            oprecision   <= '0;
            quant_msbidx <= '0;
            mul_mode     <= '0;
        end else begin
            r_abort_d <= abort;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            countdown    <= w_head.countdown;
                            wprecision   <= w_head.wprec;
                            iprecision   <= w_head.iprec;
                            oprecision   <= w_head.oprec;
                            quant_msbidx <= w_head.msbidx;
                            mul_mode     <= w_head.mul_mode;
                            r_state      <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        r_cnt   <= countdown;
                        r_state <= (countdown == '0) ? ST_DONE : ST_RUN;
                    end
                    ST_RUN: begin
                        if (r_cnt == BCNTDWN'(1)) begin
                            r_cnt   <= BCNTDWN'(QLAT);
                            r_state <= ST_QUANT;
                        end else begin
                            r_cnt <= r_cnt - BCNTDWN'(1);
                        end
                    end
                    ST_QUANT: begin
                        if (r_cnt == BCNTDWN'(1)) r_state <= ST_DONE;
                        else                      r_cnt   <= r_cnt - BCNTDWN'(1);
                    end
                    ST_DONE:  r_state <= ST_IDLE;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // First RUN/QUANT cycle is recognised by the counter still holding its load value
    assign start       = (r_state == ST_RUN)   && (r_cnt == countdown);
    assign quant_start = (r_state == ST_QUANT) && (r_cnt == BCNTDWN'(QLAT));
    // The cycle after an abort also clears the accumulator
    assign acc_clr     = (r_state == ST_SETUP) || r_abort_d;
    assign max_clr     = (r_state == ST_SETUP);
    assign quant_clr   = (r_state == ST_SETUP);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mvu_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvu_job_ctrl
//  Description : Directed self-checking bench for mvu_job_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mvu_job_ctrl;
    import mvu_pkg::*;

    localparam int QDEPTH = 2;
    localparam int QLAT   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                job_valid = 1'b0;
    logic                job_ready;
    logic [BCNTDWN-1:0]  job_countdown = '0;
    logic [BPREC-1:0]    job_wprec = '0;
    logic [BPREC-1:0]    job_iprec = '0;
    logic [BPREC-1:0]    job_oprec = '0;
    logic [BQMSBIDX-1:0] job_msbidx = '0;
    logic [1:0]          job_mul_mode = '0;
    logic                abort = 1'b0;
    logic [BCNTDWN-1:0]  countdown;
    logic [BPREC-1:0]    wprecision, iprecision, oprecision;
    logic [BQMSBIDX-1:0] quant_msbidx;
    logic [1:0]          mul_mode;
    logic                start, acc_clr, max_clr, quant_clr, quant_start, busy, done;

    mvu_job_ctrl #(.QDEPTH(QDEPTH), .QLAT(QLAT)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_countdown(job_countdown), .job_wprec(job_wprec), .job_iprec(job_iprec),
        .job_oprec(job_oprec), .job_msbidx(job_msbidx), .job_mul_mode(job_mul_mode),
        .abort(abort), .countdown(countdown), .wprecision(wprecision),
        .iprecision(iprecision), .oprecision(oprecision), .quant_msbidx(quant_msbidx),
        .mul_mode(mul_mode), .start(start), .acc_clr(acc_clr), .max_clr(max_clr),
        .quant_clr(quant_clr), .quant_start(quant_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Event log: cycle numbers of each strobe, sampled mid-cycle
    int setup_q[$], start_q[$], qs_q[$], done_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_clr && max_clr && quant_clr) setup_q.push_back(cyc);
            if (start)       start_q.push_back(cyc);
            if (quant_start) qs_q.push_back(cyc);
            if (done)        done_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        setup_q.delete();
        start_q.delete();
        qs_q.delete();
        done_q.delete();
    endtask

    // Present a descriptor and hold valid until accepted; t = cycle of the push
    task automatic push_job(input int c, input int w, input int i, input int o,
                            input int m, input int mm, output int t);
        bit ok;
        ok = 1'b0;
        t  = -1;
        job_countdown = BCNTDWN'(c);
        job_wprec     = BPREC'(w);
        job_iprec     = BPREC'(i);
        job_oprec     = BPREC'(o);
        job_msbidx    = BQMSBIDX'(m);
        job_mul_mode  = 2'(mm);
        job_valid     = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (job_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
            tick();
        end
        job_valid = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    int t0, t1, t2, a;

    initial begin
        // 1: reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ready", 64'(job_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({start, acc_clr, max_clr, quant_clr, quant_start, done}), 64'd0);
        check("rst_config", 64'({countdown, wprecision, iprecision, oprecision, quant_msbidx, mul_mode}), 64'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 2: single job, C=5
        clear_log();
        push_job(5, 3, 5, 7, 17, 2, t0);
        repeat (20) tick();
        check("j1_nsetup", 64'(setup_q.size()), 64'd1);
        check("j1_ndone", 64'(done_q.size()), 64'd1);
        if (setup_q.size() == 1 && start_q.size() == 1 && qs_q.size() == 1 && done_q.size() == 1) begin
            check("j1_setup_cyc", 64'(setup_q[0]), 64'(t0 + 2));
            check("j1_start_cyc", 64'(start_q[0]), 64'(t0 + 3));
            check("j1_qs_cyc", 64'(qs_q[0]), 64'(t0 + 8));
            check("j1_done_cyc", 64'(done_q[0]), 64'(t0 + 12));
        end else begin
            check("j1_strobe_counts", 64'(start_q.size() * 10 + qs_q.size()), 64'd11);
        end
        check("j1_cfg_hold", 64'({wprecision, iprecision, oprecision, quant_msbidx, mul_mode}),
              64'({6'd3, 6'd5, 6'd7, 5'd17, 2'd2}));
        check("j1_countdown", 64'(countdown), 64'd5);
        check("j1_idle", 64'(busy), 64'd0);

        // 3: three back-to-back jobs, C=3
        clear_log();
        push_job(3, 1, 1, 1, 1, 1, a);
        push_job(3, 2, 2, 2, 2, 2, t1);
        push_job(3, 4, 4, 4, 4, 3, t2);
        check("bb_consecutive", 64'((t1 == a + 1) && (t2 == a + 2)), 64'd1);
        check("bb_ready_full", 64'(job_ready), 64'd0);
        repeat (40) tick();
        check("bb_ndone", 64'(done_q.size()), 64'd3);
        check("bb_nstart", 64'(start_q.size()), 64'd3);
        if (done_q.size() == 3 && setup_q.size() == 3) begin
            check("bb_done0", 64'(done_q[0]), 64'(a + 10));
            check("bb_gap1", 64'(setup_q[1] - done_q[0]), 64'd2);
            check("bb_gap2", 64'(setup_q[2] - done_q[1]), 64'd2);
            check("bb_done2", 64'(done_q[2]), 64'(a + 30));
        end
        check("bb_last_cfg", 64'({wprecision, mul_mode}), 64'({6'd4, 2'd3}));

        // 4: zero-length job
        clear_log();
        push_job(0, 9, 9, 9, 9, 0, t0);
        repeat (8) tick();
        check("z_setup_cyc", 64'(setup_q.size() == 1 ? setup_q[0] : -1), 64'(t0 + 2));
        check("z_done_cyc", 64'(done_q.size() == 1 ? done_q[0] : -1), 64'(t0 + 3));
        check("z_nstart", 64'(start_q.size()), 64'd0);
        check("z_nqs", 64'(qs_q.size()), 64'd0);

        // 5: abort in second RUN cycle with one job queued
        clear_log();
        push_job(5, 1, 2, 3, 4, 1, t0);
        push_job(5, 7, 7, 7, 7, 3, t1);
        while (cyc < t0 + 4) tick();
        check("ab_in_run", 64'(busy && !start), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle", 64'(busy), 64'd0);
        check("ab_accclr", 64'(acc_clr), 64'd1);
        check("ab_maxclr", 64'(max_clr), 64'd0);
        check("ab_ready", 64'(job_ready), 64'd1);
        tick();
        check("ab_accclr_off", 64'(acc_clr), 64'd0);
        check("ab_fifo_empty", 64'(busy), 64'd0);
        repeat (20) tick();
        check("ab_ndone", 64'(done_q.size()), 64'd0);
        check("ab_nsetup", 64'(setup_q.size()), 64'd1);

        // 6: reset in QUANT with valid held
        clear_log();
        push_job(2, 5, 5, 5, 5, 1, t0);
        while (cyc < t0 + 6) tick();
        check("rq_in_quant", 64'(busy && !quant_start && qs_q.size() == 1), 64'd1);
        rst_n         = 1'b0;
        job_countdown = BCNTDWN'(1);
        job_valid     = 1'b1;
        tick();
        rst_n     = 1'b1;
        job_valid = 1'b0;
        check("rq_idle", 64'(busy), 64'd0);
        check("rq_ready", 64'(job_ready), 64'd1);
        check("rq_cfg", 64'({countdown, wprecision}), 64'd0);
        tick();
        check("rq_no_push", 64'(busy), 64'd0);
        repeat (15) tick();
        check("rq_ndone", 64'(done_q.size()), 64'd0);
        check("rq_nsetup", 64'(setup_q.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
